regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the pipeline decode/writeback stages.
//  It provides NRD combinational read ports and NWR write ports with write-first bypass.
//  A per-register pending scoreboard supports hazard detection.
//  After reset, a hardware sweep zeroes every entry, so no simulation-only init is needed.
//  Register 0 is optionally hardwired to zero.
// PARAMETERS
//  XLEN     32  data width of each register
//  NREGS    32  number of registers; power of two, >=2; AW = $clog2(NREGS) (localparam)
//  NRD      2   number of read ports, 1..4
//  NWR      1   number of write ports, 1..2; higher port index has priority
//  ZERO_REG 1   1: entry 0 reads 0, ignores writes and is never pending
// PORTS
//  clk             in   1          clock; all state updates on posedge
//  reset           in   1          synchronous, active-high reset
//  io_rd_addr      in   NRD*AW     read addresses; port i = bits [i*AW +: AW]
//  io_rd_data      out  NRD*XLEN   read data, combinational
//  io_rd_pending   out  NRD        1 = addressed register has an outstanding producer
//  io_wr_en        in   NWR        write enables
//  io_wr_addr      in   NWR*AW     write addresses
//  io_wr_data      in   NWR*XLEN   write data
//  io_sb_set_en    in   1          mark io_sb_set_addr as pending (instruction issued)
//  io_sb_set_addr  in   AW         register to mark pending
//  io_init_busy    out  1          1 while the clear sweep runs; caller must stall
// BEHAVIOUR
//  Clock and reset: single clk domain; reset is synchronous and active-high.
//  FSM states:
//   - CLEAR: entered when reset=1. The sweep counter cnt is set to 0.
//     Each cycle, entry[cnt] <= 0 and cnt++.
//     When cnt==NREGS-1 is written, the FSM moves to READY.
//     The sweep takes exactly NREGS cycles after reset deasserts.
//   - READY: normal operation. Stays in READY until reset is asserted again.
//  Reset mid-sweep or in READY: returns to CLEAR with cnt=0; the sweep fully restarts.
//  Reset values: state=CLEAR, cnt=0, all pending bits=0, io_init_busy=1.
//  Outputs during CLEAR:
//   - io_init_busy=1.
//   - io_rd_data=0 and io_rd_pending=0 on every port.
//   - io_wr_en and io_sb_set_en are ignored.
//  Writes (READY): on posedge, entry[wr_addr[j]] <= wr_data[j] for each enabled port j.
//   - Same-cycle writes to the same address: the highest-index port wins.
//   - With ZERO_REG=1, writes to address 0 are dropped.
//  Reads (READY): combinational, zero latency.
//   - Priority: ZERO_REG && addr==0 -> 0.
//   - Else, if any enabled write port targets addr this cycle -> that port's wr_data
//     (highest index wins).
//   - Else -> stored entry.
//  Scoreboard, one bit per entry:
//   - An enabled write to addr clears pend[addr] on the next edge.
//   - io_sb_set_en sets pend[sb_set_addr] on the next edge.
//   - Set and write to the same address in the same cycle: set wins, so the bit stays 1
//     (newer producer).
//   - Setting an already-pending bit keeps it at 1.
//   - With ZERO_REG=1, address 0 is never set.
//  io_rd_pending[i] = pend[rd_addr[i]] & ~(same-cycle enabled write to rd_addr[i]).
//   - A write in the same cycle bypasses, so the read is not stalled.
//   - io_rd_pending[i] is forced to 0 during CLEAR and for address 0 when ZERO_REG=1.
//  Read ports are independent; any number of ports may read the same address.
// TESTING
//  T1 Reset sweep:
//   - Stimulus: reset=1 for 3 cycles, then 0.
//   - Required: io_init_busy=1 for exactly 32 cycles after deassert, then 0.
//   - Required: afterwards all 32 entries read 0.
//  T2 Write/read and x0:
//   - Stimulus: write 0xDEADBEEF to r5 and 0x12345678 to r0.
//   - Required: next cycle, rd_addr=5 gives 0xDEADBEEF and rd_addr=0 gives 0x00000000.
//  T3 Bypass and port priority (NWR=2):
//   - Stimulus: same cycle, port0 writes 0x1111 to r7, port1 writes 0x2222 to r7,
//     and read r7.
//   - Required: read shows 0x2222 that cycle and stays 0x2222 afterwards.
//  T4 Scoreboard:
//   - Stimulus: sb_set r9, then 2 idle cycles.
//   - Required: io_rd_pending=1 for rd_addr=9.
//   - Stimulus: write r9=0xA5.
//   - Required: pending reads 0 in the write cycle (data 0xA5); pend[9]=0 after.
//   - Stimulus: set and write r9 in the same cycle.
//   - Required: pending=1 in the following cycle.
//  T5 Reset mid-sweep:
//   - Stimulus: write attempt during CLEAR at cnt=10; assert reset at cnt=20.
//   - Required: the write is ignored and the sweep restarts at cnt=0.
//   - Required: busy stays high for 32 more cycles after deassert.
//  T6 Random regression:
//   - 10k cycles of random rd/wr/sb traffic, periodic resets.
//   - Required: match against a behavioural model with the rules above for
//     NRD=3, NWR=2, NREGS=16, XLEN=64.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-first bypass, a per-entry pending
// scoreboard and a post-reset hardware sweep that zeroes every entry.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_CLEAR | sweep running: entry[r_cnt] <= 0 each cycle, ports return 0, writes ignored
// S_READY | normal operation: bypassed reads, prioritised writes, scoreboard live
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NRD*$clog2(NREGS)-1:0]       io_rd_addr,
    output logic [NRD*XLEN-1:0]                io_rd_data,
    output logic [NRD-1:0]                     io_rd_pending,
    input  logic [NWR-1:0]                     io_wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0]       io_wr_addr,
    input  logic [NWR*XLEN-1:0]                io_wr_data,
    input  logic                               io_sb_set_en,
    input  logic [$clog2(NREGS)-1:0]           io_sb_set_addr,
    output logic                               io_init_busy
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_cnt;
    logic              r_busy;
    logic [XLEN-1:0]   r_mem [NREGS];
    logic [NREGS-1:0]  r_pend;

    logic [AW-1:0]     w_wr_addr  [NWR];
    logic [XLEN-1:0]   w_wr_data  [NWR];
    logic [AW-1:0]     w_rd_addr  [NRD];
    logic              w_hit      [NRD];
    logic [XLEN-1:0]   w_rd_value [NRD];
    logic              w_ready;
    logic              w_sb_ok;

    for (genvar j = 0; j < NWR; j++) begin : g_wr
        assign w_wr_addr[j] = io_wr_addr[j*AW +: AW];
        assign w_wr_data[j] = io_wr_data[j*XLEN +: XLEN];
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign w_rd_addr[i] = io_rd_addr[i*AW +: AW];
    end

    assign w_ready      = (r_state == S_READY);
    assign w_sb_ok      = io_sb_set_en && !(ZERO_REG && (io_sb_set_addr == '0));
    assign io_init_busy = r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == AW'(NREGS - 1)) begin
                r_state <= S_READY;
                r_busy  <= 1'b0;
            end
        end
    end

    // Later ports are visited last, so their non-blocking write wins on collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    if (io_wr_en[j] && !(ZERO_REG && (w_wr_addr[j] == '0))) begin
                        r_mem[w_wr_addr[j]] <= w_wr_data[j];
                    end
                end
            end
        end
    end

    // A same-cycle set overrides a write's clear: the newer producer owns the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else if (w_ready) begin
            for (int j = 0; j < NWR; j++) begin
                if (io_wr_en[j]) begin
                    r_pend[w_wr_addr[j]] <= 1'b0;
                end
            end
            if (w_sb_ok) begin
                r_pend[io_sb_set_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            w_hit[i]      = 1'b0;
            w_rd_value[i] = r_mem[w_rd_addr[i]];
            for (int j = 0; j < NWR; j++) begin
                if (io_wr_en[j] && (w_wr_addr[j] == w_rd_addr[i])) begin
                    w_hit[i]      = 1'b1;
                    w_rd_value[i] = w_wr_data[j];
                end
            end
        end
    end

    always_comb begin
        io_rd_data    = '0;
        io_rd_pending = '0;
        for (int i = 0; i < NRD; i++) begin
            if (w_ready && !(ZERO_REG && (w_rd_addr[i] == '0))) begin
                io_rd_data[i*XLEN +: XLEN] = w_rd_value[i];
                io_rd_pending[i]           = r_pend[w_rd_addr[i]] & ~w_hit[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vectors on a 32x32 2R/2W instance, then random
// traffic on a 16x64 3R/2W instance against a behavioural model.
module tb_regfile_mp;
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // directed instance: XLEN=32, NREGS=32, NRD=2, NWR=2
    logic         d_reset;
    logic [9:0]   d_rd_addr;
    logic [63:0]  d_rd_data;
    logic [1:0]   d_rd_pend;
    logic [1:0]   d_wr_en;
    logic [9:0]   d_wr_addr;
    logic [63:0]  d_wr_data;
    logic         d_sb_en;
    logic [4:0]   d_sb_addr;
    logic         d_busy;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1'b1)) u_dir (
        .clk(clk), .reset(d_reset),
        .io_rd_addr(d_rd_addr), .io_rd_data(d_rd_data), .io_rd_pending(d_rd_pend),
        .io_wr_en(d_wr_en), .io_wr_addr(d_wr_addr), .io_wr_data(d_wr_data),
        .io_sb_set_en(d_sb_en), .io_sb_set_addr(d_sb_addr), .io_init_busy(d_busy)
    );

    // random instance: XLEN=64, NREGS=16, NRD=3, NWR=2
    logic         q_reset;
    logic [11:0]  q_rd_addr;
    logic [191:0] q_rd_data;
    logic [2:0]   q_rd_pend;
    logic [1:0]   q_wr_en;
    logic [7:0]   q_wr_addr;
    logic [127:0] q_wr_data;
    logic         q_sb_en;
    logic [3:0]   q_sb_addr;
    logic         q_busy;

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(2), .ZERO_REG(1'b1)) u_rnd (
        .clk(clk), .reset(q_reset),
        .io_rd_addr(q_rd_addr), .io_rd_data(q_rd_data), .io_rd_pending(q_rd_pend),
        .io_wr_en(q_wr_en), .io_wr_addr(q_wr_addr), .io_wr_data(q_wr_data),
        .io_sb_set_en(q_sb_en), .io_sb_set_addr(q_sb_addr), .io_init_busy(q_busy)
    );

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        sb;
        logic [4:0]  sba;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        ep0;
        logic        ep1;
    } vec_t;

    vec_t vt[$];

    // behavioural model of the random instance
    logic [63:0] m_mem  [16];
    bit          m_pend [16];
    int          m_busy_left;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_idle();
        d_wr_en   = '0;
        d_wr_addr = '0;
        d_wr_data = '0;
        d_sb_en   = 1'b0;
        d_sb_addr = '0;
    endtask

    initial begin
        int n;
        int rst_hold;
        logic [3:0]  a;
        logic [3:0]  wa [2];
        logic [63:0] ed;
        logic        ep;
        logic        hit;

        d_reset = 1'b1; d_rd_addr = '0; d_idle();
        q_reset = 1'b1; q_rd_addr = '0; q_wr_en = '0; q_wr_addr = '0; q_wr_data = '0;
        q_sb_en = 1'b0; q_sb_addr = '0;
        tick();

        // T1: reset values, 3-cycle reset, 32-cycle sweep, all entries zero
        d_rd_addr = {5'd9, 5'd5};
        #3;
        chk("rst_busy", 64'(d_busy), 64'd1);
        chk("rst_data", d_rd_data, 64'd0);
        chk("rst_pend", 64'(d_rd_pend), 64'd0);
        tick(); tick();
        d_reset = 1'b0;
        n = 0;
        while (d_busy && n < 100) begin
            n++;
            tick();
        end
        chk("t1_busy_cycles", 64'(n), 64'd32);
        chk("t1_busy_after", 64'(d_busy), 64'd0);
        for (int k = 0; k < 32; k++) begin
            d_rd_addr = {5'(31 - k), 5'(k)};
            #3;
            chk($sformatf("t1_zero[%0d]", k), d_rd_data, 64'd0);
            tick();
        end

        // T2..T4 as one-cycle vectors
        vt.push_back(vec_t'{2'b11, 5'd5, 32'hDEADBEEF, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0});
        vt.push_back(vec_t'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0});
        vt.push_back(vec_t'{2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 1'b0, 5'd0, 5'd7, 5'd5, 32'h2222, 32'hDEADBEEF, 1'b0, 1'b0});
        vt.push_back(vec_t'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h2222, 32'h2222, 1'b0, 1'b0});
        vt.push_back(vec_t'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0});
        vt.push_back(vec_t'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h0, 32'h0, 1'b1, 1'b1});
        vt.push_back(vec_t'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0});
        vt.push_back(vec_t'{2'b01, 5'd9, 32'hA5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7, 32'hA5, 32'h2222, 1'b0, 1'b0});
        vt.push_back(vec_t'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'hA5, 32'hA5, 1'b0, 1'b0});
        vt.push_back(vec_t'{2'b10, 5'd0, 32'h0, 5'd9, 32'h77, 1'b1, 5'd9, 5'd9, 5'd9, 32'h77, 32'h77, 1'b0, 1'b0});
        vt.push_back(vec_t'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h77, 32'h0, 1'b1, 1'b0});
        vt.push_back(vec_t'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h77, 1'b0, 1'b1});
        vt.push_back(vec_t'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h77, 1'b0, 1'b1});
        vt.push_back(vec_t'{2'b11, 5'd3, 32'hAAAA, 5'd4, 32'hBBBB, 1'b0, 5'd0, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0});
        vt.push_back(vec_t'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9, 32'hAAAA, 32'h77, 1'b0, 1'b1});
        vt.push_back(vec_t'{2'b01, 5'd0, 32'h99, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h77, 1'b0, 1'b1});

        foreach (vt[v]) begin
            d_wr_en   = vt[v].wen;
            d_wr_addr = {vt[v].wa1, vt[v].wa0};
            d_wr_data = {vt[v].wd1, vt[v].wd0};
            d_sb_en   = vt[v].sb;
            d_sb_addr = vt[v].sba;
            d_rd_addr = {vt[v].ra1, vt[v].ra0};
            #3;
            chk($sformatf("vec%0d_d0", v), 64'(d_rd_data[31:0]), 64'(vt[v].ed0));
            chk($sformatf("vec%0d_d1", v), 64'(d_rd_data[63:32]), 64'(vt[v].ed1));
            chk($sformatf("vec%0d_p0", v), 64'(d_rd_pend[0]), 64'(vt[v].ep0));
            chk($sformatf("vec%0d_p1", v), 64'(d_rd_pend[1]), 64'(vt[v].ep1));
            tick();
        end
        d_idle();

        // T5: write attempt at cnt=10, reset at cnt=20, full restart
        d_reset = 1'b1;
        tick();
        d_reset = 1'b0;
        repeat (10) tick();
        d_wr_en = 2'b01; d_wr_addr = {5'd0, 5'd3}; d_wr_data = {32'h0, 32'h5555};
        d_sb_en = 1'b1; d_sb_addr = 5'd3; d_rd_addr = {5'd0, 5'd3};
        #3;
        chk("t5_busy_mid", 64'(d_busy), 64'd1);
        chk("t5_clear_data", d_rd_data, 64'd0);
        chk("t5_clear_pend", 64'(d_rd_pend), 64'd0);
        tick();
        d_idle();
        repeat (9) tick();
        d_reset = 1'b1;
        tick();
        d_reset = 1'b0;
        n = 0;
        while (d_busy && n < 100) begin
            if (n == 25) begin
                d_wr_en = 2'b11; d_wr_addr = {5'd3, 5'd3}; d_wr_data = {32'h6666, 32'h5555};
                d_sb_en = 1'b1; d_sb_addr = 5'd3;
            end else begin
                d_idle();
            end
            n++;
            tick();
        end
        d_idle();
        chk("t5_busy_cycles", 64'(n), 64'd32);
        d_rd_addr = {5'd10, 5'd3};
        #3;
        chk("t5_r3_data", 64'(d_rd_data[31:0]), 64'd0);
        chk("t5_r10_data", 64'(d_rd_data[63:32]), 64'd0);
        chk("t5_r3_pend", 64'(d_rd_pend), 64'd0);
        tick();

        // T6: random traffic against the model; q_reset has been high for many edges
        m_busy_left = 16;
        foreach (m_pend[k]) m_pend[k] = 1'b0;
        rst_hold = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (rst_hold > 0) begin
                q_reset = 1'b1;
                rst_hold--;
            end else if (cyc > 0 && ($urandom_range(0, 599) == 0 ||
                         (m_busy_left > 0 && $urandom_range(0, 99) == 0))) begin
                q_reset  = 1'b1;
                rst_hold = $urandom_range(0, 2);
            end else begin
                q_reset = 1'b0;
            end
            for (int j = 0; j < 2; j++) begin
                q_wr_en[j]           = 1'($urandom_range(0, 1));
                q_wr_addr[j*4 +: 4]  = 4'($urandom_range(0, 15));
                q_wr_data[j*64 +: 64] = {$urandom(), $urandom()};
                wa[j]                = q_wr_addr[j*4 +: 4];
            end
            q_sb_en   = ($urandom_range(0, 3) == 0);
            q_sb_addr = 4'($urandom_range(0, 15));
            for (int i = 0; i < 3; i++) q_rd_addr[i*4 +: 4] = 4'($urandom_range(0, 15));
            #3;

            chk($sformatf("rnd%0d_busy", cyc), 64'(q_busy), 64'(m_busy_left > 0));
            for (int i = 0; i < 3; i++) begin
                a  = q_rd_addr[i*4 +: 4];
                ed = '0;
                ep = 1'b0;
                if (m_busy_left == 0 && a != 4'd0) begin
                    hit = 1'b0;
                    ed  = m_mem[a];
                    for (int j = 0; j < 2; j++) begin
                        if (q_wr_en[j] && wa[j] == a) begin
                            hit = 1'b1;
                            ed  = q_wr_data[j*64 +: 64];
                        end
                    end
                    ep = m_pend[a] && !hit;
                end
                chk($sformatf("rnd%0d_data%0d", cyc, i), q_rd_data[i*64 +: 64], ed);
                chk($sformatf("rnd%0d_pend%0d", cyc, i), 64'(q_rd_pend[i]), 64'(ep));
            end

            if (q_reset) begin
                m_busy_left = 16;
                foreach (m_pend[k]) m_pend[k] = 1'b0;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) foreach (m_mem[k]) m_mem[k] = '0;
            end else begin
                for (int j = 0; j < 2; j++) begin
                    if (q_wr_en[j]) begin
                        if (wa[j] != 4'd0) m_mem[wa[j]] = q_wr_data[j*64 +: 64];
                        m_pend[wa[j]] = 1'b0;
                    end
                end
                if (q_sb_en && q_sb_addr != 4'd0) m_pend[q_sb_addr] = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
